// File: rtl/sc_pkg.sv
// sc_pkg: shared types, stream length and bit-reversal helper for stochastic-computing lanes
package sc_pkg;
    localparam int SC_BITSTREAM = 64;
    typedef enum logic {SC_UNARY = 1'b0, SC_BITREV = 1'b1} sc_mode_e;
    typedef enum logic {SNG_IDLE = 1'b0, SNG_STREAM = 1'b1} sng_state_e;
    function automatic logic [31:0] sc_bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < width) r[i[4:0]] = value[5'(width - 1 - i)];
        return r;
    endfunction
endpackage

// File: rtl/sc_bit_cmp.sv
// sc_bit_cmp: stream bit = (position < quota), position is cnt or its bit-reversal
module sc_bit_cmp
    import sc_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] cnt_i,
    input  logic [W-1:0] quota_i,
    input  sc_mode_e     mode_i,
    output logic         bit_o
);
    logic [W-1:0] pos;
    assign pos   = (mode_i == SC_BITREV) ? W'(sc_bitrev(32'(cnt_i), W)) : cnt_i;
    assign bit_o = pos < quota_i;
endmodule

// File: rtl/quota_sng.sv
// quota_sng: turns one quota Q per transaction into a BITSTREAM-bit serial stream with exactly Q ones
module quota_sng
    import sc_pkg::*;
#(
    parameter int BITSTREAM = SC_BITSTREAM
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(BITSTREAM)-1:0] in_quota,
    input  logic                         in_mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_bit,
    output logic                         out_first,
    output logic                         out_last
);
    localparam int BS_W = $clog2(BITSTREAM);
    if (BITSTREAM < 2 || (BITSTREAM & (BITSTREAM - 1)) != 0) begin : g_bad_len
        $error("quota_sng: BITSTREAM must be a power of two >= 2");
    end
    sng_state_e      state_q, state_d;
    logic [BS_W-1:0] cnt_q, cnt_d, quota_q, quota_d;
    sc_mode_e        mode_q, mode_d;
    logic            accept, beat, cmp_bit;
    assign out_valid = state_q == SNG_STREAM;
    assign out_first = out_valid && cnt_q == '0;
    assign out_last  = out_valid && &cnt_q;
    assign in_ready  = !rst && (!out_valid || (out_last && out_ready));
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign out_bit   = out_valid && cmp_bit;
    sc_bit_cmp #(.W(BS_W)) u_cmp (
        .cnt_i   (cnt_q),
        .quota_i (quota_q),
        .mode_i  (mode_q),
        .bit_o   (cmp_bit)
    );
    // an accept on the last beat overrides the return to idle, giving bubble-free streams
    always_comb begin
        state_d = accept ? SNG_STREAM : (beat && out_last) ? SNG_IDLE : state_q;
        cnt_d   = accept ? '0 : beat ? cnt_q + BS_W'(1) : cnt_q;
        quota_d = accept ? in_quota : quota_q;
        mode_d  = accept ? sc_mode_e'(in_mode) : mode_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SNG_IDLE;
            cnt_q   <= '0;
            quota_q <= '0;
            mode_q  <= SC_UNARY;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quota_q <= quota_d;
            mode_q  <= mode_d;
        end
    end
endmodule

// File: tb/tb_quota_sng.sv
// tb_quota_sng: directed and randomized checks of quota_sng with BITSTREAM=64
module tb_quota_sng;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_quota = '0;
    logic       in_mode = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_bit, out_first, out_last;
    int         n_cmp = 0;
    int         n_bad = 0;

    quota_sng #(.BITSTREAM(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_quota  (in_quota),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input int q, input bit m);
        int t = 0;
        in_valid = 1'b1;
        in_quota = 6'(q);
        in_mode  = m;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) check_eq("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // drains the current stream from beat index start; returns at the negedge after the last beat
    task automatic collect(input int stall_pct, input int start, output int beats, output int ones,
                           output logic [63:0] bits, output int ferr);
        int t = 0;
        bit done = 0;
        beats = start;
        ones  = 0;
        bits  = '0;
        ferr  = 0;
        while (!done && t < 2000) begin
            out_ready = ($urandom_range(99) >= stall_pct);
            #1;
            if (!out_valid) ferr++;
            if (out_first !== (beats == 0) || out_last !== (beats == 63)) ferr++;
            if (out_valid && out_ready) begin
                bits[beats[5:0]] = out_bit;
                ones += int'(out_bit);
                done = out_last;
                beats++;
            end
            @(negedge clk);
            t++;
        end
        if (!done) check_eq("collect_timeout", 0, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        int beats, ones, ferr, rdy_cnt, rdy_at, bad_streams;
        logic [63:0] bits;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_bit", out_bit, 0);
        check_eq("rst_flags", {out_first, out_last}, 0);
        check_eq("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("idle_in_ready", in_ready, 1);

        send(5, 0);
        #1;
        check_eq("u5_latency_first", {out_valid, out_first}, 2'b11);
        collect(0, 0, beats, ones, bits, ferr);
        check_eq("u5_beats", beats, 64);
        check_eq("u5_ones", ones, 5);
        check_eq("u5_bits", bits, 64'h1F);
        check_eq("u5_flags", ferr, 0);
        #1;
        check_eq("u5_idle_after", {out_valid, in_ready}, 2'b01);

        @(negedge clk);
        send(32, 1);
        collect(0, 0, beats, ones, bits, ferr);
        check_eq("r32_bits", bits, 64'h5555_5555_5555_5555);
        check_eq("r32_ones", ones, 32);
        check_eq("r32_flags", ferr, 0);

        send(0, 1);
        collect(0, 0, beats, ones, bits, ferr);
        check_eq("q0_bits", bits, 64'h0);
        check_eq("q0_beats", beats, 64);
        check_eq("q0_flags", ferr, 0);

        send(3, 0);
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("bp_hold", {out_valid, out_bit, out_first, out_last, in_ready}, 5'b11000);
            @(negedge clk);
        end
        collect(0, 2, beats, ones, bits, ferr);
        check_eq("bp_beats", beats, 64);
        check_eq("bp_tail_bits", bits, 64'h4);
        check_eq("bp_tail_ones", ones, 1);
        check_eq("bp_flags", ferr, 0);

        send(10, 0);
        in_valid = 1'b1;
        in_quota = 6'd63;
        in_mode  = 1'b1;
        rdy_cnt = 0;
        rdy_at  = -1;
        ones    = 0;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (in_ready) begin
                rdy_cnt++;
                rdy_at = i;
            end
            ones += int'(out_bit);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("b2b_ready_count", rdy_cnt, 1);
        check_eq("b2b_ready_beat", rdy_at, 63);
        check_eq("b2b_first_ones", ones, 10);
        #1;
        check_eq("b2b_no_bubble", {out_valid, out_first}, 2'b11);
        collect(0, 0, beats, ones, bits, ferr);
        check_eq("b2b_second_bits", bits, 64'h7FFF_FFFF_FFFF_FFFF);
        check_eq("b2b_second_ones", ones, 63);
        check_eq("b2b_flags", ferr, 0);

        send(9, 0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_rst_abandon", {out_valid, out_last, in_ready}, 3'b000);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ready", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        send(7, 0);
        collect(0, 0, beats, ones, bits, ferr);
        check_eq("post_rst_ones", ones, 7);
        check_eq("post_rst_beats", beats, 64);

        bad_streams = 0;
        for (int s = 0; s < 400; s++) begin
            automatic int q = $urandom_range(63);
            automatic int m = $urandom_range(1);
            automatic int exp_bits_ones = q;
            send(q, m[0]);
            collect(25, 0, beats, ones, bits, ferr);
            if (beats != 64 || ones != exp_bits_ones || ferr != 0) bad_streams++;
        end
        check_eq("random_bad_streams", bad_streams, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
